// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: register numbers, exception type codes, ExcCode values,
// Status/Cause bit positions and the exception vectors.
package cp0_exc_unit_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_NONE     = 32'h0;
    localparam logic [31:0] EXC_INT      = 32'h1;
    localparam logic [31:0] EXC_SYSCALL  = 32'h8;
    localparam logic [31:0] EXC_INVALID  = 32'ha;
    localparam logic [31:0] EXC_TRAP     = 32'hd;
    localparam logic [31:0] EXC_OVERFLOW = 32'hc;
    localparam logic [31:0] EXC_ERET     = 32'he;

    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;
    localparam logic [4:0] EXCCODE_TR  = 5'd13;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_BD  = 31;

    localparam int FLAG_SYSCALL  = 8;
    localparam int FLAG_INVALID  = 9;
    localparam int FLAG_TRAP     = 10;
    localparam int FLAG_OVERFLOW = 11;
    localparam int FLAG_ERET     = 12;

    // Software-writable Cause bits: IV, WP, IP[1:0]
    localparam logic [31:0] CAUSE_WMASK = 32'h00c0_0300;
    localparam logic [31:0] RESET_STATUS = 32'h1000_0000;

    localparam logic [31:0] VEC_INT = 32'h0000_0020;
    localparam logic [31:0] VEC_EXC = 32'h0000_0040;

    function automatic logic [4:0] exccode_of(input logic [31:0] t);
        case (t)
            EXC_SYSCALL:  return EXCCODE_SYS;
            EXC_INVALID:  return EXCCODE_RI;
            EXC_TRAP:     return EXCCODE_TR;
            EXC_OVERFLOW: return EXCCODE_OV;
            default:      return EXCCODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, sticky match interrupt cleared by
// any write to Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (compare != 32'd0 && count == compare) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file and MEM-stage exception arbiter.
// Define CP0_TIMER_EN to include the Count/Compare timer.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] mem_excflags_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, cause_q, epc_q;
    logic [31:0] count, compare;
    logic        wr_status, wr_cause, wr_epc;
    logic        irq_pending, exc_take;
    logic        unused_flags;

    assign unused_flags = ^{mem_excflags_i[31:13], mem_excflags_i[7:0]};

    assign wr_status = we_i && (waddr_i == REG_STATUS);
    assign wr_cause  = we_i && (waddr_i == REG_CAUSE);
    assign wr_epc    = we_i && (waddr_i == REG_EPC);

    // WB-stage mtc0 is forwarded so a same-cycle write is seen by the arbiter
    assign status_o = wr_status ? wdata_i : status_q;
    assign cause_o  = wr_cause ? ((cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK)) : cause_q;
    assign epc_o    = wr_epc ? wdata_i : epc_q;

    assign irq_pending = (|(cause_o[15:8] & status_o[15:8])) && !status_o[ST_EXL] && status_o[ST_IE];

    always_comb begin
        excepttype_o = EXC_NONE;
        if (mem_pc_i != 32'd0) begin
            if (irq_pending)                         excepttype_o = EXC_INT;
            else if (mem_excflags_i[FLAG_SYSCALL])   excepttype_o = EXC_SYSCALL;
            else if (mem_excflags_i[FLAG_INVALID])   excepttype_o = EXC_INVALID;
            else if (mem_excflags_i[FLAG_TRAP])      excepttype_o = EXC_TRAP;
            else if (mem_excflags_i[FLAG_OVERFLOW])  excepttype_o = EXC_OVERFLOW;
            else if (mem_excflags_i[FLAG_ERET])      excepttype_o = EXC_ERET;
        end
    end

    assign exc_take = (excepttype_o != EXC_NONE) && (excepttype_o != EXC_ERET);

    // mtc0 lands first; exception commit then overrides only the fields it owns
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= RESET_STATUS;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            status_q       <= status_o;
            cause_q        <= cause_o;
            cause_q[15:10] <= int_i;
            epc_q          <= epc_o;
            if (exc_take) begin
                if (!status_o[ST_EXL]) begin
                    epc_q         <= mem_in_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
                    cause_q[CA_BD] <= mem_in_delayslot_i;
                end
                status_q[ST_EXL] <= 1'b1;
                cause_q[6:2]     <= exccode_of(excepttype_o);
            end else if (excepttype_o == EXC_ERET) begin
                status_q[ST_EXL] <= 1'b0;
            end
        end
    end

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we_i && (waddr_i == REG_COUNT)),
        .compare_we (we_i && (waddr_i == REG_COMPARE)),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int_o)
    );
`else
    assign count       = '0;
    assign compare     = '0;
    assign timer_int_o = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_COUNT:   rdata_o = count;
            REG_COMPARE: rdata_o = compare;
            REG_STATUS:  rdata_o = status_q;
            REG_CAUSE:   rdata_o = cause_q;
            REG_EPC:     rdata_o = epc_q;
            REG_PRID:    rdata_o = PRID_VALUE;
            REG_CONFIG:  rdata_o = CONFIG_VALUE;
            default:     rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus random traffic
// against a behavioural CP0 model.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] wdata_i, rdata_o;
    logic [31:0] mem_excflags_i, mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] excepttype_o, epc_o, status_o, cause_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .int_i(int_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .mem_excflags_i(mem_excflags_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i),
        .excepttype_o(excepttype_o), .epc_o(epc_o),
        .status_o(status_o), .cause_o(cause_o), .timer_int_o(timer_int_o)
    );

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // architectural model state
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    logic        m_tint;
    // model view of this cycle's combinational outputs
    logic [31:0] e_status, e_cause, e_epc, e_code, e_rdata;

    task automatic model_comb();
        logic irq;
        e_status = (we_i && waddr_i == 5'd12) ? wdata_i : m_status;
        e_cause  = (we_i && waddr_i == 5'd13) ?
                   ((m_cause & ~32'h00c00300) | (wdata_i & 32'h00c00300)) : m_cause;
        e_epc    = (we_i && waddr_i == 5'd14) ? wdata_i : m_epc;
        irq = ((e_cause[15:8] & e_status[15:8]) != 8'd0) && !e_status[1] && e_status[0];
        if (mem_pc_i == 32'd0)          e_code = 32'h0;
        else if (irq)                   e_code = 32'h1;
        else if (mem_excflags_i[8])     e_code = 32'h8;
        else if (mem_excflags_i[9])     e_code = 32'ha;
        else if (mem_excflags_i[10])    e_code = 32'hd;
        else if (mem_excflags_i[11])    e_code = 32'hc;
        else if (mem_excflags_i[12])    e_code = 32'he;
        else                            e_code = 32'h0;
        case (raddr_i)
            5'd9:    e_rdata = m_count;
            5'd11:   e_rdata = m_compare;
            5'd12:   e_rdata = m_status;
            5'd13:   e_rdata = m_cause;
            5'd14:   e_rdata = m_epc;
            5'd15:   e_rdata = 32'h004c0102;
            5'd16:   e_rdata = 32'h00008000;
            default: e_rdata = 32'h0;
        endcase
    endtask

    task automatic model_seq();
        logic nt;
        model_comb();
        if (rst) begin
            m_status = 32'h1000_0000; m_cause = 0; m_epc = 0;
            m_count = 0; m_compare = 0; m_tint = 1'b0;
            return;
        end
        if (TIMER) begin
            nt = m_tint;
            if (we_i && waddr_i == 5'd11) nt = 1'b0;
            else if (m_compare != 0 && m_count == m_compare) nt = 1'b1;
            m_tint  = nt;
            m_count = (we_i && waddr_i == 5'd9) ? wdata_i : m_count + 1;
            if (we_i && waddr_i == 5'd11) m_compare = wdata_i;
        end
        m_status = e_status;
        m_cause  = e_cause;
        m_cause[15:10] = int_i;
        m_epc    = e_epc;
        if (e_code inside {32'h1, 32'h8, 32'ha, 32'hd, 32'hc}) begin
            if (!e_status[1]) begin
                m_epc = mem_in_delayslot_i ? mem_pc_i - 4 : mem_pc_i;
                m_cause[31] = mem_in_delayslot_i;
            end
            m_status[1] = 1'b1;
            m_cause[6:2] = (e_code == 32'h1) ? 5'd0 : e_code[4:0];
        end else if (e_code == 32'he) begin
            m_status[1] = 1'b0;
        end
    endtask

    // apply inputs just after a falling edge and check the model's view
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [5:0] iv, input logic [31:0] fl,
                         input logic [31:0] pc, input logic ds);
        we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra; int_i = iv;
        mem_excflags_i = fl; mem_pc_i = pc; mem_in_delayslot_i = ds;
        #1;
        model_comb();
        check("excepttype", excepttype_o, e_code);
        check("epc_o", epc_o, e_epc);
        check("status_o", status_o, e_status);
        check("cause_o", cause_o, e_cause);
        check("timer_int", 32'(timer_int_o), 32'(m_tint));
        if (!(we && wa == ra)) check("rdata", rdata_o, e_rdata);
    endtask

    task automatic idle(input logic [4:0] ra);
        drive(1'b0, 5'd0, 32'h0, ra, 6'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    initial begin
        int wa_tab [9] = '{9, 11, 12, 13, 14, 15, 16, 3, 0};
        logic [31:0] fl, pc;
        bit got_tint;

        rst = 1'b1;
        we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 0; int_i = 0;
        mem_excflags_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        idle(5'd12);
        check("rst_status", rdata_o, 32'h1000_0000);
        check("rst_epc", epc_o, 32'h0);
        check("rst_code", excepttype_o, 32'h0);
        check("rst_tint", 32'(timer_int_o), 32'h0);

        // interrupt in a delay slot
        drive(1'b1, 5'd12, 32'h0000_0401, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 6'b000001, 32'h0, 32'h0, 1'b0); tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 6'b000001, 32'h0, 32'h100, 1'b1);
        check("irq_code", excepttype_o, 32'h1);
        tick();
        idle(5'd14);
        check("irq_epc", rdata_o, 32'hfc);
        check("irq_bd", 32'(cause_o[31]), 32'h1);
        check("irq_exl", 32'(status_o[1]), 32'h1);
        check("irq_exccode", 32'(cause_o[6:2]), 32'h0);

        // priority: syscall over overflow
        drive(1'b1, 5'd12, 32'h0, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 6'd0, 32'h0900, 32'h200, 1'b0);
        check("prio_code", excepttype_o, 32'h8);
        tick();
        idle(5'd0);
        check("prio_exccode", 32'(cause_o[6:2]), 32'd8);
        check("prio_epc", epc_o, 32'h200);
        check("prio_bd", 32'(cause_o[31]), 32'h0);

        // nested: EXL already set
        drive(1'b0, 5'd0, 32'h0, 5'd0, 6'd0, 32'h0800, 32'h300, 1'b0);
        check("nest_code", excepttype_o, 32'hc);
        tick();
        idle(5'd0);
        check("nest_epc", epc_o, 32'h200);
        check("nest_exccode", 32'(cause_o[6:2]), 32'd12);

        // bubble suppresses flags
        drive(1'b0, 5'd0, 32'h0, 5'd0, 6'd0, 32'h0100, 32'h0, 1'b0);
        check("bubble_code", excepttype_o, 32'h0);
        tick();

        // eret with same-cycle EPC write
        drive(1'b1, 5'd14, 32'h400, 5'd0, 6'd0, 32'h1000, 32'h304, 1'b0);
        check("eret_epc_bp", epc_o, 32'h400);
        check("eret_code", excepttype_o, 32'he);
        tick();
        idle(5'd0);
        check("eret_exl", 32'(status_o[1]), 32'h0);
        check("eret_epc", epc_o, 32'h400);

        // timer
        if (TIMER) begin
            drive(1'b1, 5'd11, 32'd5, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
            drive(1'b1, 5'd9, 32'd0, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
            got_tint = 1'b0;
            for (int i = 0; i < 20; i++) begin
                idle(5'd9);
                if (timer_int_o) begin got_tint = 1'b1; break; end
                tick();
            end
            check("tint_set", 32'(got_tint), 32'h1);
            check("tint_count", rdata_o, 32'd6);
            drive(1'b1, 5'd11, 32'd7, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
            idle(5'd0);
            check("tint_clear", 32'(timer_int_o), 32'h0);
            drive(1'b1, 5'd9, 32'hffff_ffff, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
            idle(5'd9);
            check("count_max", rdata_o, 32'hffff_ffff);
            tick();
            idle(5'd9);
            check("count_wrap", rdata_o, 32'h0);
        end else begin
            drive(1'b1, 5'd9, 32'h1234, 5'd0, 6'd0, 32'h0, 32'h0, 1'b0); tick();
            drive(1'b1, 5'd11, 32'h1, 5'd9, 6'd0, 32'h0, 32'h0, 1'b0);
            check("count_off", rdata_o, 32'h0);
            tick();
            idle(5'd11);
            check("compare_off", rdata_o, 32'h0);
            check("tint_off", 32'(timer_int_o), 32'h0);
        end
        tick();

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            fl = $urandom;
            if ($urandom_range(0, 1) == 0) fl[12:8] = 5'd0;
            pc = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hffff_fffc);
            drive($urandom_range(0, 3) == 0, 5'(wa_tab[$urandom_range(0, 8)]), $urandom,
                  5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), fl, pc,
                  1'($urandom_range(0, 1)));
            tick();
        end

        // reset dominates a same-cycle write and exception
        rst = 1'b1;
        drive(1'b1, 5'd12, 32'h0000_0003, 5'd0, 6'd0, 32'h0100, 32'h500, 1'b0);
        tick();
        rst = 1'b0;
        idle(5'd12);
        check("rstdom_status", rdata_o, 32'h1000_0000);
        check("rstdom_epc", epc_o, 32'h0);
        check("rstdom_cause", cause_o, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
